mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single CPU-side memory port between two masters:
  - the UART programming loader, which writes program bytes;
  - the CPU data port.
- Arbitration is round-robin. While `programming` is high, only the loader is served.
- Request fields are registered at grant, and each transfer is completed with a one-cycle done pulse.
- An optional watchdog aborts transfers that the memory never acknowledges.

## Interface
Parameters:
- AW, default `ADDR_WIDTH`: address width.
- DW, default `DATA_WIDTH`: data width.
- TIMEOUT_CYCLES, default 255: watchdog limit in cycles, 8-bit counter. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- programming  in  1  programming mode; only loader requests are eligible while high.
- ldr_req, ldr_we  in  1  loader request and write enable.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_gnt  out  1  loader owns the port.
- ldr_done  out  1  one-cycle completion pulse to the loader.
- cpu_req, cpu_we  in  1  CPU request and write enable.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU owns the port.
- cpu_done  out  1  one-cycle completion pulse to the CPU.
- rdata  out  DW  registered read data, valid when either done is high.
- err  out  1  high together with done if the transfer timed out.
- mem_req, mem_we  out  1  memory request and write enable, registered.
- mem_addr  out  AW  memory address, registered.
- mem_wdata  out  DW  memory write data, registered.
- mem_rdata  in  DW  memory read data.
- mem_ack  in  1  memory completion, one cycle.

## Operation
States:
- IDLE: no owner.
- LDR_XFER: loader owns the port.
- CPU_XFER: CPU owns the port.
- DONE: completion cycle.

Transitions:
- IDLE -> LDR_XFER or CPU_XFER per the arbitration rules below. At the transition edge, the winner's we/addr/wdata are captured into the mem_* registers and `mem_req` is set.
- XFER -> DONE on `mem_ack`. `mem_rdata` is captured into `rdata`, `mem_req` is cleared, and `last_owner` is updated.
- DONE -> IDLE unconditionally.

Arbitration in IDLE:
- Eligible requesters:
  - `programming`=1: loader only. `cpu_req` is ignored.
  - `programming`=0: both requesters.
- One eligible requester: it wins.
- Both eligible: the requester that is not `last_owner` wins.
- `last_owner` resets to CPU, so the loader wins the first tie.

Outputs per state:
- `ldr_gnt` and `cpu_gnt` are high for the whole matching XFER state.
- In DONE, exactly one of `ldr_done` / `cpu_done` is high, the one matching the previous owner.
- `rdata` holds its value until the next capture. Writes capture `mem_rdata` as-is.

Requester handshake:
- Requesters hold req and fields stable until done; fields are sampled only at grant.
- The arbiter never samples req in DONE. A req still high in the IDLE cycle after DONE is a new request.

Programming changes mid-transfer:
- A `programming` change during XFER does not abort the transfer.
- It affects only the next IDLE arbitration.

## Timing
- Reset, asynchronous and active-low:
  - state = IDLE; `last_owner` = CPU; watchdog counter = 0.
  - All outputs 0: `ldr_gnt`, `cpu_gnt`, `ldr_done`, `cpu_done`, `rdata`, `err`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`.
- Reset mid-transfer drops `mem_req` immediately and no done pulse is issued.
- Latency:
  - req sampled high at edge N gives `mem_req`/gnt high after edge N.
  - `mem_ack` sampled at edge N+k gives done high for the cycle after edge N+k.
  - Back in IDLE after edge N+k+1.
  - Minimum req-to-done is 2 cycles; back-to-back grants are every 3 cycles minimum.
- `mem_ack` outside XFER is ignored.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to XFER and increments each XFER cycle without `mem_ack`.
  - When the counter equals TIMEOUT_CYCLES, the next edge goes to DONE with `err`=1, `rdata`=0 and `mem_req` cleared.
  - `mem_ack` in the same cycle as expiry wins: normal completion with `err`=0.
- ARB_TIMEOUT_EN undefined:
  - No counter; XFER waits indefinitely.
  - The `err` port remains and is tied to 0.

## Test plan
- Reset sequencing: drive `rst`=0 mid LDR_XFER -> all outputs 0 asynchronously. Release, then `cpu_req`=1 -> `cpu_gnt` after 1 edge.
- Programming write: `programming`=1, `ldr_req` write addr 0x4 data 0xA5, `cpu_req`=1, ack after 2 cycles -> `mem_addr`=0x4, `mem_wdata`=0xA5, `mem_we`=1, `ldr_done` for 1 cycle; `cpu_gnt` never asserts while `programming`=1.
- Round-robin: `programming`=0, both reqs held high, ack always 1 cycle -> grants alternate LDR, CPU, LDR, CPU; each done 3 cycles apart.
- CPU read: `cpu_req` read addr 0x10, `mem_rdata`=0xDEADBEEF with ack -> `cpu_done`=1 and `rdata`=0xDEADBEEF in the same cycle; `rdata` holds afterwards.
- Timeout with ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4:
  - no ack -> `cpu_done`=1, `err`=1, `rdata`=0 at cycle 6 after grant;
  - ack on the expiry cycle -> `err`=0.
- Field stability: change `cpu_addr` 0x10 -> 0x20 during CPU_XFER -> `mem_addr` stays 0x10 until done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one memory port between the UART programming loader and the CPU
// data port. Round-robin arbitration between the two; while `programming`
// is high only the loader is eligible. The winner's request fields are
// registered into the mem_* outputs at grant. Each transfer ends with a
// one-cycle done pulse to its owner, with read data registered in `rdata`.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : an 8-bit watchdog aborts a transfer after TIMEOUT_CYCLES
//               cycles without mem_ack (done with err=1, rdata=0).
//   Undefined : transfers wait indefinitely for mem_ack; err is tied to 0.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   programming          programming mode (loader-only arbitration)
//   ldr_req/we/addr/wdata loader request and fields
//   ldr_gnt, ldr_done    loader owns port / loader completion pulse
//   cpu_req/we/addr/wdata CPU request and fields
//   cpu_gnt, cpu_done    CPU owns port / CPU completion pulse
//   rdata, err           registered read data / timeout flag, valid with done
//   mem_req/we/addr/wdata registered memory request
//   mem_rdata, mem_ack   memory read data and one-cycle completion
//   fsm_state            current FSM state, for observation
//
// Handshake: a requester raises req with stable fields and holds them until
// its done pulse. Fields are sampled only on the grant edge. The memory
// side sees mem_req held high until it returns a single-cycle mem_ack;
// mem_ack seen while no transfer is in progress is ignored.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int AW             = `ADDR_WIDTH,
  parameter int DW             = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          programming,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_done,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LDR_XFER = 2'd1,
    CPU_XFER = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state_q, state_d;

  // 1 when the loader owned the most recent completed transfer. Resets to
  // 0 (CPU) so the loader wins the first tie.
  logic last_ldr_q;

  logic ldr_elig, cpu_elig;
  logic pick_ldr, pick_cpu;
  logic in_xfer;
  logic expire;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  assign ldr_elig = ldr_req;
  assign cpu_elig = cpu_req & ~programming;

  // Loader wins when alone, or on a tie when it was not the last owner.
  assign pick_ldr = ldr_elig & (~cpu_elig | ~last_ldr_q);
  assign pick_cpu = cpu_elig & ~pick_ldr;

  assign in_xfer = (state_q == LDR_XFER) || (state_q == CPU_XFER);

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = TIMEOUT_CYCLES[7:0];

  logic [7:0] wd_cnt_q;
  logic       err_q;

  // mem_ack in the expiry cycle takes priority: normal completion.
  assign expire = in_xfer & ~mem_ack & (wd_cnt_q == TO_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= 8'd0;
    end else if (state_q == IDLE) begin
      // Held at zero outside transfers, so it is zero on XFER entry.
      wd_cnt_q <= 8'd0;
    end else if (in_xfer && !mem_ack) begin
      wd_cnt_q <= wd_cnt_q + 8'd1;
    end
  end

  // err is set on the edge into DONE and cleared on the edge out of it,
  // since expire can only be true in an XFER state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= expire;
    end
  end

  assign err = err_q;
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES[7:0];
  assign expire         = 1'b0;
  assign err            = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ldr) begin
          state_d = LDR_XFER;
        end else if (pick_cpu) begin
          state_d = CPU_XFER;
        end
      end
      LDR_XFER, CPU_XFER: begin
        if (mem_ack || expire) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registered memory request, read data and ownership history
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      last_ldr_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (pick_ldr) begin
          mem_req   <= 1'b1;
          mem_we    <= ldr_we;
          mem_addr  <= ldr_addr;
          mem_wdata <= ldr_wdata;
        end else if (pick_cpu) begin
          mem_req   <= 1'b1;
          mem_we    <= cpu_we;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
        end
      end else if (in_xfer && (mem_ack || expire)) begin
        mem_req    <= 1'b0;
        // Writes also capture mem_rdata unchanged; a timeout returns zero.
        rdata      <= mem_ack ? mem_rdata : '0;
        last_ldr_q <= (state_q == LDR_XFER);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Grant / done outputs decoded from state
  // ---------------------------------------------------------------------
  // In DONE, last_ldr_q already names the owner of the finishing transfer.
  assign ldr_gnt   = (state_q == LDR_XFER);
  assign cpu_gnt   = (state_q == CPU_XFER);
  assign ldr_done  = (state_q == DONE) &  last_ldr_q;
  assign cpu_done  = (state_q == DONE) & ~last_ldr_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// -------------------
// Directed self-checking bench for mem_port_arbiter (AW=DW=32,
// TIMEOUT_CYCLES=4). Inputs change and outputs are sampled 1 ns after
// each rising edge. Grant order in the round-robin section is checked
// against an expected-owner queue.

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // Owner codes: {cpu, ldr}
  localparam logic [1:0] OWN_LDR = 2'b01;
  localparam logic [1:0] OWN_CPU = 2'b10;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------
  // DUT
  // -------------------------------------------------------------------
  logic          programming;
  logic          ldr_req, ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt, ldr_done;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_done;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    fsm_state;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .programming(programming),
    .ldr_req(ldr_req),
    .ldr_we(ldr_we),
    .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt),
    .ldr_done(ldr_done),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt),
    .cpu_done(cpu_done),
    .rdata(rdata),
    .err(err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .fsm_state(fsm_state)
  );

  // -------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------
  int n_cmp;
  int n_err;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_inputs();
    programming = 1'b0;
    ldr_req     = 1'b0;
    ldr_we      = 1'b0;
    ldr_addr    = '0;
    ldr_wdata   = '0;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    mem_rdata   = '0;
    mem_ack     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ldr_gnt"},   ldr_gnt,   0);
    check({tag, "_cpu_gnt"},   cpu_gnt,   0);
    check({tag, "_ldr_done"},  ldr_done,  0);
    check({tag, "_cpu_done"},  cpu_done,  0);
    check({tag, "_rdata"},     rdata,     0);
    check({tag, "_err"},       err,       0);
    check({tag, "_mem_req"},   mem_req,   0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  int unsigned last_done_cyc;
  int unsigned done_cyc;
  logic [1:0]  exp_own;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    idle_inputs();
    ticks(3);

    // ---- reset state ----
    check_all_zero("rst");
    check("rst_state", fsm_state, 0);
    rst = 1'b1;
    tick();

    // ---- programming write; CPU request ignored ----
    programming = 1'b1;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h4; ldr_wdata = 32'hA5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    tick();
    check("pw_ldr_gnt",   ldr_gnt,   1);
    check("pw_cpu_gnt",   cpu_gnt,   0);
    check("pw_mem_req",   mem_req,   1);
    check("pw_mem_we",    mem_we,    1);
    check("pw_mem_addr",  mem_addr,  32'h4);
    check("pw_mem_wdata", mem_wdata, 32'hA5);
    tick();
    check("pw_wait_gnt",  ldr_gnt,   1);
    check("pw_wait_done", ldr_done,  0);
    check("pw_wait_cpu",  cpu_gnt,   0);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    check("pw_ldr_done",  ldr_done,  1);
    check("pw_cpu_done",  cpu_done,  0);
    check("pw_mem_req_clr", mem_req, 0);
    check("pw_ldr_gnt_clr", ldr_gnt, 0);
    check("pw_rdata",     rdata,     32'h55);
    mem_ack = 1'b0; mem_rdata = '0;
    ldr_req = 1'b0;
    tick();
    check("pw_done_pulse", ldr_done, 0);
    check("pw_idle",      fsm_state, 0);
    tick();
    check("pw_cpu_blocked", cpu_gnt, 0);
    check("pw_still_idle", fsm_state, 0);

    // ---- CPU read with field stability ----
    programming = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    tick();
    check("rd_cpu_gnt",  cpu_gnt,  1);
    check("rd_mem_we",   mem_we,   0);
    check("rd_mem_addr", mem_addr, 32'h10);
    cpu_addr = 32'h20;
    tick();
    check("rd_addr_stable", mem_addr, 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("rd_cpu_done", cpu_done, 1);
    check("rd_rdata",    rdata,    32'hDEADBEEF);
    check("rd_addr_hold", mem_addr, 32'h10);
    mem_ack = 1'b0; mem_rdata = '0; cpu_req = 1'b0;
    tick();
    check("rd_done_pulse", cpu_done, 0);
    check("rd_rdata_hold", rdata, 32'hDEADBEEF);

    // ---- mem_ack outside a transfer is ignored ----
    mem_ack = 1'b1; mem_rdata = 32'h1111;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("stray_ack_state", fsm_state, 0);
    check("stray_ack_rdata", rdata, 32'hDEADBEEF);
    tick();
    check("stray_ack_done", {cpu_done, ldr_done}, 0);

    // ---- round robin (last owner CPU -> loader first) ----
    exp_q.push_back(OWN_LDR);
    exp_q.push_back(OWN_CPU);
    exp_q.push_back(OWN_LDR);
    exp_q.push_back(OWN_CPU);
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h100; ldr_wdata = 32'h77;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    last_done_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      exp_own = exp_q.pop_front();
      tick();
      check("rr_gnt", {cpu_gnt, ldr_gnt}, exp_own);
      check("rr_addr", mem_addr, (exp_own == OWN_LDR) ? 32'h100 : 32'h30);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      done_cyc = cyc;
      check("rr_done", {cpu_done, ldr_done}, exp_own);
      if (i > 0) check("rr_done_spacing", done_cyc - last_done_cyc, 3);
      last_done_cyc = done_cyc;
      if (i == 3) begin
        ldr_req = 1'b0;
        cpu_req = 1'b0;
      end
      tick();
    end
    check("rr_queue_empty", exp_q.size(), 0);
    tick();
    check("rr_end_idle", fsm_state, 0);

    // ---- reset mid loader transfer ----
    programming = 1'b1;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h8; ldr_wdata = 32'h3C;
    tick();
    check("mr_ldr_gnt", ldr_gnt, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mr");
    tick();
    check("mr_held_state", fsm_state, 0);
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
    rst = 1'b1;
    tick();
    check("mr_cpu_gnt", cpu_gnt, 1);
    check("mr_cpu_addr", mem_addr, 32'h44);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    check("mr_cpu_done", cpu_done, 1);
    check("mr_rdata", rdata, 32'h12345678);
    mem_ack = 1'b0; mem_rdata = '0; cpu_req = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // ---- watchdog: no ack ----
    cpu_req = 1'b1; cpu_addr = 32'h50;
    tick();
    check("to_gnt", cpu_gnt, 1);
    ticks(4);
    check("to_not_yet", cpu_done, 0);
    check("to_still_gnt", cpu_gnt, 1);
    tick();
    check("to_cpu_done", cpu_done, 1);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    check("to_mem_req", mem_req, 0);
    cpu_req = 1'b0;
    tick();
    check("to_err_pulse", err, 0);
    tick();

    // ---- watchdog: ack on the expiry cycle wins ----
    cpu_req = 1'b1;
    tick();
    ticks(4);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    tick();
    check("toa_done", cpu_done, 1);
    check("toa_err", err, 0);
    check("toa_rdata", rdata, 32'hCAFE);
    mem_ack = 1'b0; mem_rdata = '0; cpu_req = 1'b0;
    tick();
`else
    // ---- no watchdog: transfer waits indefinitely ----
    cpu_req = 1'b1; cpu_addr = 32'h50;
    tick();
    ticks(10);
    check("nw_still_gnt", cpu_gnt, 1);
    check("nw_no_done", cpu_done, 0);
    check("nw_err", err, 0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    tick();
    check("nw_done", cpu_done, 1);
    check("nw_err_done", err, 0);
    check("nw_rdata", rdata, 32'hCAFE);
    mem_ack = 1'b0; mem_rdata = '0; cpu_req = 1'b0;
    tick();
`endif
    check("end_idle", fsm_state, 0);

    // -------------------------------------------------------------------
    // Report
    // -------------------------------------------------------------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
